// File: rtl/serial_receiver_pkg.sv
// Shared definitions for the serial byte link: frame layout constants that the
// transmitter also uses, the receiver FSM state encoding and small helpers
// for deriving counter sizes from the bit period.
package serial_receiver_pkg;

    // Frame layout: one start bit, DATA_BITS data bits LSB first, one stop bit.
    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_e;

    // Offset from the first low cycle to the start-bit sample point.
    function automatic int half_period(input int clks_per_bit);
        return (clks_per_bit - 1) / 2;
    endfunction

    // Width of a down-counter that must hold values up to clks_per_bit-1.
    function automatic int count_width(input int clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/serial_receiver_bit_synchronizer.sv
// Multi-flop synchronizer for the asynchronous serial line. Every stage resets
// to 1 so the receiver sees an idle (high) line straight out of reset.
module serial_receiver_bit_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the raw line through the flop chain; the oldest stage is the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/serial_receiver.sv
// Receive end of the serial byte link. Detects the start bit on the
// synchronized line, samples the start, data and stop bits near the middle
// of each bit period, and hands completed bytes to the consumer through a
// valid/ack holding register with overrun and frame-error reporting.
module serial_receiver
    import serial_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 rx_clk,
    input  logic                 reset,
    input  logic                 data_in,
    input  logic                 data_ack,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 overrun,
    output logic                 rx_busy
);

    localparam int HALF   = half_period(CLKS_PER_BIT);
    localparam int CNT_W  = count_width(CLKS_PER_BIT);
    localparam int BIDX_W = $clog2(DATA_BITS);

    // Reload values for the sample-point counter: the counter runs down to
    // zero and the line is sampled in the cycle where it reads zero.
    localparam logic [CNT_W-1:0]  CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF_END = (HALF > 0) ? CNT_W'(HALF - 1) : '0;
    localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
    localparam logic [BIDX_W-1:0] BIDX_ONE     = BIDX_W'(1);
    localparam logic [BIDX_W-1:0] LAST_BIT     = BIDX_W'(DATA_BITS - 1);

    // With no half-period offset the first low cycle is itself the start-bit
    // sample, so the FSM skips START entirely.
    localparam logic FAST_START = (HALF == 0);

    logic                 rxs;
    rx_state_e            state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BIDX_W-1:0]    bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 frame_error_q;
    logic [DATA_BITS-1:0] data_out_q;
    logic                 data_valid_q;
    logic                 overrun_q;
    logic                 sample_tick;
    logic                 commit_d;

    serial_receiver_bit_synchronizer #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (rx_clk),
        .rst (reset),
        .d_i (data_in),
        .q_o (rxs)
    );

    assign sample_tick = (cnt_q == '0);

    // A byte is accepted in the stop-bit sample cycle when the line is high;
    // it becomes visible on the outputs one cycle later.
    assign commit_d = (state_q == STOP) && sample_tick && (rxs == STOP_LEVEL);

    // Frame FSM: start detection, bit sampling, stop check and break recovery.
    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            frame_error_q <= 1'b0;
        end else begin
            frame_error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rxs == START_LEVEL) begin
                        bit_idx_q <= '0;
                        if (FAST_START) begin
                            state_q <= DATA;
                            cnt_q   <= CNT_BIT_END;
                        end else begin
                            state_q <= START;
                            cnt_q   <= CNT_HALF_END;
                        end
                    end
                end
                START: begin
                    if (sample_tick) begin
                        if (rxs == START_LEVEL) begin
                            state_q <= DATA;
                            cnt_q   <= CNT_BIT_END;
                        end else begin
                            // Line went back high before mid-bit: a glitch, not a frame.
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                DATA: begin
                    if (sample_tick) begin
                        shift_q   <= {rxs, shift_q[DATA_BITS-1:1]};
                        cnt_q     <= CNT_BIT_END;
                        bit_idx_q <= bit_idx_q + BIDX_ONE;
                        if (bit_idx_q == LAST_BIT) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                STOP: begin
                    if (sample_tick) begin
                        if (rxs == STOP_LEVEL) begin
                            state_q <= IDLE;
                        end else begin
                            // Bad stop bit: report once, then wait out any break.
                            state_q       <= WAIT_HIGH;
                            frame_error_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                WAIT_HIGH: begin
                    if (rxs == STOP_LEVEL) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Holding register and consumer handshake; a commit takes priority over an ack.
    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (commit_d) begin
                data_out_q   <= shift_q;
                data_valid_q <= 1'b1;
                // Previous byte never consumed: it is lost, flag it.
                if (data_valid_q && !data_ack) begin
                    overrun_q <= 1'b1;
                end
            end else if (data_valid_q && data_ack) begin
                data_valid_q <= 1'b0;
                overrun_q    <= 1'b0;
            end
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;
    assign rx_busy     = (state_q == START) || (state_q == DATA) || (state_q == STOP) ||
                         (FAST_START && (state_q == IDLE) && (rxs == START_LEVEL));

endmodule
